ball_renderer_pipe: RTL and testbench
=====================================

// Module: ball_renderer_pipe
// PURPOSE
//  Pipelined multi-ball renderer for the VGA path (1024x768, 12-bit RGB): draws up to N_BALLS
//  filled or ring circles, each with its own centre, colour and enable, and outputs one pixel per clock.
//  Position updates from the control/physics side go into shadow registers through a valid/ready port.
//  Shadow values are copied to the active set only at frame start, so a frame never tears.
//  Pixel output is fully registered; hsync/vsync/blank are delayed by the same latency.
// PARAMETERS
//  N_BALLS       4   number of ball channels (1..8); channel 0 has highest draw priority
//  RADIUS        8   outer radius in pixels (1..63); pixel drawn when d2 <= RADIUS^2
//  INNER_RADIUS  0   0 = filled disc; >0 = ring, also requires d2 >= INNER_RADIUS^2 (< RADIUS)
//  IDX_W         2   width of wr_idx_in, = max(1, clog2(N_BALLS))
// PORTS
//  clk_in        in   1      pixel clock (65 MHz)
//  rst_in        in   1      synchronous reset, active-high
//  hcount_in     in   11     pixel number on current line
//  vcount_in     in   10     line number
//  hsync_in      in   1      horizontal sync, active-low, aligned with hcount_in
//  vsync_in      in   1      vertical sync, active-low
//  blank_in      in   1      1 = outside active video
//  wr_valid_in   in   1      ball update request
//  wr_ready_out  out  1      update accepted when wr_valid_in & wr_ready_out
//  wr_idx_in     in   IDX_W  channel to update
//  wr_x_in       in   11     ball centre x
//  wr_y_in       in   10     ball centre y
//  wr_color_in   in   12     ball colour
//  wr_en_in      in   1      1 = ball visible
//  pixel_out     out  12     rendered pixel, 0 when blanked or no hit
//  hit_out       out  N_BALLS per-channel hit for this pixel, before priority (collision debug)
//  hsync_out     out  1      hsync_in delayed 3 clocks
//  vsync_out     out  1      vsync_in delayed 3 clocks
//  blank_out     out  1      blank_in delayed 3 clocks
// BEHAVIOUR
//  Reset: all shadow and active regs -> x=0, y=0, color=0, en=0; pixel_out=0; hit_out=0;
//   blank_out=1; hsync_out=vsync_out=1; all pipeline stage regs cleared to the same values.
//   wr_ready_out=0 during reset and 1 from the first cycle after rst_in drops.
//  Commit: the cycle with hcount_in==0 && vcount_in==0 copies every shadow entry to the active set.
//   wr_ready_out=0 in that cycle only, so a write and a commit never coincide.
//   A write accepted on the cycle before commit is included in that commit.
//  Write: on handshake, shadow[wr_idx_in] <= {x,y,color,en}.
//   If wr_idx_in >= N_BALLS, the write is accepted and discarded.
//   A repeated write to the same index before commit: the last write wins.
//  Pipeline, latency 3 clocks from hcount/vcount/syncs in to pixel/syncs out:
//   S1: per channel dx = {1'b0,hcount} - {1'b0,x} (12-bit signed); dy = vcount - y (11-bit signed).
//       Register the results and the syncs/blank.
//   S2: register dx*dx and dy*dy (unsigned, 22/20 bits), computed with no truncation.
//   S3: d2 = sum (23 bits); hit[i] = en[i] & (d2 <= RADIUS^2) & (INNER_RADIUS==0 | d2 >= INNER_RADIUS^2).
//       pixel_out = blank ? 0 : color of the lowest-index hit channel, else 0.
//       hit_out = hit (not masked by blank).
//  Centre-based coordinates: balls near or past the screen edges clip naturally, with no wrap-around.
//   Example: x=0 draws only the right half of the disc.
//  The active set is read in S1 only, so a commit lands on pixel (0,0) of the new frame with no mixing.
//  Reset mid-frame: outputs return to reset values on the next clock; rendering resumes at the
//   next commit with empty (disabled) balls.
// TESTING
//  1 Reset, write idx0 {x=100,y=100,F00,en=1}, run a frame -> no pixels in frame 0;
//    frame 1 pixel (100,100) appears 3 clocks after input = F00.
//  2 RADIUS=8: pixel (108,100) -> F00; (109,100) -> 0; (106,106) (d2=72) -> 0; (105,106) (d2=61) -> F00.
//  3 Overlap: idx0 F00 at (200,200), idx1 0F0 at (204,200); pixel (202,200)
//    -> pixel_out=F00, hit_out=4'b0011.
//  4 Write held valid during (0,0) -> wr_ready_out=0 for exactly 1 clock, write lands the next cycle;
//    visible next frame, not this one.
//  5 INNER_RADIUS=4: centre (300,300) -> 0; (304,300) -> colour; blank_in=1 with hit -> pixel_out=0, hit_out set.
//  6 Edge ball x=0,y=0: (0,0) -> colour; (1023,0) -> 0 (no wrap); wr_idx_in=3 with N_BALLS=3 -> accepted, no effect.

Source files
------------

// File: rtl/ball_renderer_pipe.sv
// Multi-ball circle renderer: 3-stage pipeline from VGA counters to one 12-bit RGB pixel per clock.
// Ball updates land in shadow registers and are copied to the active set at pixel (0,0).
module ball_renderer_pipe #(
  parameter int N_BALLS      = 4,
  parameter int RADIUS       = 8,
  parameter int INNER_RADIUS = 0,
  parameter int IDX_W        = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               blank_in,
  input  logic               wr_valid_in,
  output logic               wr_ready_out,
  input  logic [IDX_W-1:0]   wr_idx_in,
  input  logic [10:0]        wr_x_in,
  input  logic [9:0]         wr_y_in,
  input  logic [11:0]        wr_color_in,
  input  logic               wr_en_in,
  output logic [11:0]        pixel_out,
  output logic [N_BALLS-1:0] hit_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               blank_out
);

  localparam logic [22:0] R2  = 23'(RADIUS * RADIUS);
  localparam logic [22:0] IR2 = 23'(INNER_RADIUS * INNER_RADIUS);

  logic [10:0]        sh_x     [N_BALLS];
  logic [9:0]         sh_y     [N_BALLS];
  logic [11:0]        sh_color [N_BALLS];
  logic [N_BALLS-1:0] sh_en;
  logic [10:0]        act_x     [N_BALLS];
  logic [9:0]         act_y     [N_BALLS];
  logic [11:0]        act_color [N_BALLS];
  logic [N_BALLS-1:0] act_en;

  logic commit;
  logic wr_fire;

  assign commit       = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign wr_ready_out = ~rst_in & ~commit;
  assign wr_fire      = wr_valid_in & wr_ready_out;

  // Writes never coincide with a commit, so the copy always sees settled shadow values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < N_BALLS; i++) begin
        sh_x[i]      <= '0;
        sh_y[i]      <= '0;
        sh_color[i]  <= '0;
        act_x[i]     <= '0;
        act_y[i]     <= '0;
        act_color[i] <= '0;
      end
      sh_en  <= '0;
      act_en <= '0;
    end else begin
      if (commit) begin
        for (int i = 0; i < N_BALLS; i++) begin
          act_x[i]     <= sh_x[i];
          act_y[i]     <= sh_y[i];
          act_color[i] <= sh_color[i];
        end
        act_en <= sh_en;
      end
      if (wr_fire) begin
        for (int i = 0; i < N_BALLS; i++) begin
          if (wr_idx_in == IDX_W'(i)) begin
            sh_x[i]     <= wr_x_in;
            sh_y[i]     <= wr_y_in;
            sh_color[i] <= wr_color_in;
            sh_en[i]    <= wr_en_in;
          end
        end
      end
    end
  end

  // Pixel (0,0) already renders with the freshly committed set.
  logic [10:0]        eff_x     [N_BALLS];
  logic [9:0]         eff_y     [N_BALLS];
  logic [11:0]        eff_color [N_BALLS];
  logic [N_BALLS-1:0] eff_en;

  always_comb begin
    for (int i = 0; i < N_BALLS; i++) begin
      eff_x[i]     = commit ? sh_x[i]     : act_x[i];
      eff_y[i]     = commit ? sh_y[i]     : act_y[i];
      eff_color[i] = commit ? sh_color[i] : act_color[i];
    end
    eff_en = commit ? sh_en : act_en;
  end

  logic signed [11:0] s1_dx    [N_BALLS];
  logic signed [10:0] s1_dy    [N_BALLS];
  logic [11:0]        s1_color [N_BALLS];
  logic [N_BALLS-1:0] s1_en;
  logic [2:0]         s1_sync;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < N_BALLS; i++) begin
        s1_dx[i]    <= '0;
        s1_dy[i]    <= '0;
        s1_color[i] <= '0;
      end
      s1_en   <= '0;
      s1_sync <= 3'b111;
    end else begin
      for (int i = 0; i < N_BALLS; i++) begin
        s1_dx[i]    <= {1'b0, hcount_in} - {1'b0, eff_x[i]};
        s1_dy[i]    <= {1'b0, vcount_in} - {1'b0, eff_y[i]};
        s1_color[i] <= eff_color[i];
      end
      s1_en   <= eff_en;
      s1_sync <= {hsync_in, vsync_in, blank_in};
    end
  end

  // Squaring the magnitude keeps the multiplier unsigned; |dx| <= 2047 and |dy| <= 1023.
  logic [10:0] abs_dx [N_BALLS];
  logic [9:0]  abs_dy [N_BALLS];

  always_comb begin
    for (int i = 0; i < N_BALLS; i++) begin
      abs_dx[i] = s1_dx[i][11] ? 11'(-s1_dx[i]) : s1_dx[i][10:0];
      abs_dy[i] = s1_dy[i][10] ? 10'(-s1_dy[i]) : s1_dy[i][9:0];
    end
  end

  logic [21:0]        s2_dx2   [N_BALLS];
  logic [19:0]        s2_dy2   [N_BALLS];
  logic [11:0]        s2_color [N_BALLS];
  logic [N_BALLS-1:0] s2_en;
  logic [2:0]         s2_sync;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < N_BALLS; i++) begin
        s2_dx2[i]   <= '0;
        s2_dy2[i]   <= '0;
        s2_color[i] <= '0;
      end
      s2_en   <= '0;
      s2_sync <= 3'b111;
    end else begin
      for (int i = 0; i < N_BALLS; i++) begin
        s2_dx2[i]   <= {11'd0, abs_dx[i]} * {11'd0, abs_dx[i]};
        s2_dy2[i]   <= {10'd0, abs_dy[i]} * {10'd0, abs_dy[i]};
        s2_color[i] <= s1_color[i];
      end
      s2_en   <= s1_en;
      s2_sync <= s1_sync;
    end
  end

  logic [22:0]        d2 [N_BALLS];
  logic [N_BALLS-1:0] ring_ok;
  logic [N_BALLS-1:0] hit;
  logic [11:0]        px;

  always_comb begin
    for (int i = 0; i < N_BALLS; i++) begin
      d2[i] = {1'b0, s2_dx2[i]} + {3'b000, s2_dy2[i]};
    end
  end

  if (INNER_RADIUS == 0) begin : g_disc
    assign ring_ok = '1;
  end else begin : g_ring
    for (genvar i = 0; i < N_BALLS; i++) begin : g_ch
      assign ring_ok[i] = (d2[i] >= IR2);
    end
  end

  // Walk from the highest index down so channel 0 ends up on top.
  always_comb begin
    hit = '0;
    px  = '0;
    for (int i = N_BALLS - 1; i >= 0; i--) begin
      hit[i] = s2_en[i] & (d2[i] <= R2) & ring_ok[i];
      if (hit[i]) px = s2_color[i];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pixel_out <= '0;
      hit_out   <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      blank_out <= 1'b1;
    end else begin
      pixel_out <= s2_sync[0] ? 12'd0 : px;
      hit_out   <= hit;
      hsync_out <= s2_sync[2];
      vsync_out <= s2_sync[1];
      blank_out <= s2_sync[0];
    end
  end

endmodule

// File: tb/tb_ball_renderer_pipe.sv
// Scoreboard bench for ball_renderer_pipe: a filled-disc instance (4 balls) and a ring instance
// (3 balls, inner radius 4) share one stimulus stream and are checked against a behavioural model.
module tb_ball_renderer_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, blank;
  logic        wr_valid;
  logic [1:0]  wr_idx;
  logic [10:0] wr_x;
  logic [9:0]  wr_y;
  logic [11:0] wr_color;
  logic        wr_en;

  logic        ready_a, hs_a, vs_a, bl_a;
  logic [11:0] pix_a;
  logic [3:0]  hit_a;
  logic        ready_b, hs_b, vs_b, bl_b;
  logic [11:0] pix_b;
  logic [2:0]  hit_b;

  always #5 clk = ~clk;

  ball_renderer_pipe #(.N_BALLS(4), .RADIUS(8), .INNER_RADIUS(0), .IDX_W(2)) dut_a (
    .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
    .hsync_in(hsync), .vsync_in(vsync), .blank_in(blank),
    .wr_valid_in(wr_valid), .wr_ready_out(ready_a), .wr_idx_in(wr_idx),
    .wr_x_in(wr_x), .wr_y_in(wr_y), .wr_color_in(wr_color), .wr_en_in(wr_en),
    .pixel_out(pix_a), .hit_out(hit_a), .hsync_out(hs_a), .vsync_out(vs_a), .blank_out(bl_a)
  );

  ball_renderer_pipe #(.N_BALLS(3), .RADIUS(8), .INNER_RADIUS(4), .IDX_W(2)) dut_b (
    .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
    .hsync_in(hsync), .vsync_in(vsync), .blank_in(blank),
    .wr_valid_in(wr_valid), .wr_ready_out(ready_b), .wr_idx_in(wr_idx),
    .wr_x_in(wr_x), .wr_y_in(wr_y), .wr_color_in(wr_color), .wr_en_in(wr_en),
    .pixel_out(pix_b), .hit_out(hit_b), .hsync_out(hs_b), .vsync_out(vs_b), .blank_out(bl_b)
  );

  typedef struct {
    int          due;
    logic [11:0] px_a;
    logic [3:0]  hit_a;
    logic [11:0] px_b;
    logic [2:0]  hit_b;
    logic [5:0]  syncs;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state, [instance][channel]
  int m_sx[2][4], m_sy[2][4], m_sc[2][4], m_se[2][4];
  int m_ax[2][4], m_ay[2][4], m_ac[2][4], m_ae[2][4];
  int m_n[2]  = '{4, 3};
  int m_ir[2] = '{0, 4};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, want);
    end
  endtask

  function automatic void modelClear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) begin
        m_sx[d][i] = 0; m_sy[d][i] = 0; m_sc[d][i] = 0; m_se[d][i] = 0;
        m_ax[d][i] = 0; m_ay[d][i] = 0; m_ac[d][i] = 0; m_ae[d][i] = 0;
      end
  endfunction

  function automatic void modelEval(input int d, input int h, input int v, input bit use_sh,
                                    input bit blk, output logic [11:0] px, output logic [3:0] hit);
    int x, y, c, e, dx, dy, dist2;
    px  = '0;
    hit = '0;
    for (int i = m_n[d] - 1; i >= 0; i--) begin
      x = use_sh ? m_sx[d][i] : m_ax[d][i];
      y = use_sh ? m_sy[d][i] : m_ay[d][i];
      c = use_sh ? m_sc[d][i] : m_ac[d][i];
      e = use_sh ? m_se[d][i] : m_ae[d][i];
      dx = h - x;
      dy = v - y;
      dist2 = dx * dx + dy * dy;
      if (e != 0 && dist2 <= 64 && (m_ir[d] == 0 || dist2 >= m_ir[d] * m_ir[d])) begin
        hit[i] = 1'b1;
        px = 12'(c);
      end
    end
    if (blk) px = '0;
  endfunction

  task automatic applyStimulus(input bit r, input int h, input int v, input bit blk,
                               input bit wv, input int widx, input int wx, input int wy,
                               input int wc, input bit we);
    exp_t e;
    bit commit, ready, hs, vs;
    logic [11:0] pa, pb;
    logic [3:0]  ha, hb;
    @(posedge clk);
    #1;
    hs = 1'($urandom);
    vs = 1'($urandom);
    rst = r; hcount = 11'(h); vcount = 10'(v);
    hsync = hs; vsync = vs; blank = blk;
    wr_valid = wv; wr_idx = 2'(widx); wr_x = 11'(wx); wr_y = 10'(wy);
    wr_color = 12'(wc); wr_en = we;
    commit = (h == 0) && (v == 0);
    ready  = !r && !commit;
    e.due = cyc + 3;
    if (r) begin
      e.px_a = '0; e.hit_a = '0; e.px_b = '0; e.hit_b = '0; e.syncs = 6'b111111;
      foreach (sb_q[j]) begin
        if (sb_q[j].due > cyc) begin
          sb_q[j].px_a = '0; sb_q[j].hit_a = '0;
          sb_q[j].px_b = '0; sb_q[j].hit_b = '0;
          sb_q[j].syncs = 6'b111111;
        end
      end
      modelClear();
    end else begin
      modelEval(0, h, v, commit, blk, pa, ha);
      modelEval(1, h, v, commit, blk, pb, hb);
      e.px_a = pa; e.hit_a = ha; e.px_b = pb; e.hit_b = hb[2:0];
      e.syncs = {hs, vs, blk, hs, vs, blk};
      for (int d = 0; d < 2; d++) begin
        if (commit)
          for (int i = 0; i < 4; i++) begin
            m_ax[d][i] = m_sx[d][i]; m_ay[d][i] = m_sy[d][i];
            m_ac[d][i] = m_sc[d][i]; m_ae[d][i] = m_se[d][i];
          end
        if (wv && ready && widx < m_n[d]) begin
          m_sx[d][widx] = wx; m_sy[d][widx] = wy;
          m_sc[d][widx] = wc; m_se[d][widx] = int'(we);
        end
      end
    end
    sb_q.push_back(e);
    #1;
    checkOutput("wr_ready_a", 32'(ready_a), 32'(ready));
    checkOutput("wr_ready_b", 32'(ready_b), 32'(ready));
  endtask

  task automatic drivePixel(input int h, input int v, input bit blk);
    applyStimulus(0, h, v, blk, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic writeBall(input int idx, input int x, input int y, input int c, input bit en);
    applyStimulus(0, 700, 500, 0, 1, idx, x, y, c, en);
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      mon_e = sb_q.pop_front();
      if (mon_e.due < cyc) begin
        checkOutput("sb_due", 32'(cyc), 32'(mon_e.due));
      end else begin
        checkOutput("pixel_a", 32'(pix_a), 32'(mon_e.px_a));
        checkOutput("hit_a", 32'(hit_a), 32'(mon_e.hit_a));
        checkOutput("pixel_b", 32'(pix_b), 32'(mon_e.px_b));
        checkOutput("hit_b", 32'(hit_b), 32'(mon_e.hit_b));
        checkOutput("syncs", 32'({hs_a, vs_a, bl_a, hs_b, vs_b, bl_b}), 32'(mon_e.syncs));
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1; hcount = '0; vcount = '0; hsync = 1'b0; vsync = 1'b0; blank = 1'b0;
    wr_valid = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_color = '0; wr_en = 1'b0;
    modelClear();
    $display("[TB] start");

    repeat (4) applyStimulus(1, 100, 100, 0, 1, 0, 100, 100, 'hF00, 1);

    // Frame 0: ball written but not yet committed
    writeBall(0, 100, 100, 'hF00, 1);
    drivePixel(100, 100, 0);
    drivePixel(108, 100, 0);
    drivePixel(0, 0, 0);
    drivePixel(100, 100, 0);
    drivePixel(108, 100, 0);
    drivePixel(109, 100, 0);
    drivePixel(106, 106, 0);
    drivePixel(105, 106, 0);
    drivePixel(92, 100, 0);
    drivePixel(100, 92, 0);

    // Overlapping balls, idx1 written twice (last write wins)
    writeBall(0, 200, 200, 'hF00, 1);
    writeBall(1, 204, 200, 'h0FF, 1);
    writeBall(1, 204, 200, 'h0F0, 1);
    drivePixel(0, 0, 0);
    drivePixel(202, 200, 0);
    drivePixel(210, 200, 0);
    drivePixel(193, 200, 0);
    for (int k = 0; k < 40; k++)
      drivePixel($urandom_range(188, 216), $urandom_range(190, 210), ($urandom_range(0, 3) == 0));

    // Write held valid across the commit pixel
    applyStimulus(0, 0, 0, 0, 1, 2, 400, 400, 'h00F, 1);
    applyStimulus(0, 1, 0, 0, 1, 2, 400, 400, 'h00F, 1);
    drivePixel(406, 400, 0);
    drivePixel(0, 0, 0);
    drivePixel(406, 400, 0);
    drivePixel(400, 400, 0);

    // Ring vs disc, blanking with a hit
    writeBall(0, 300, 300, 'h123, 1);
    drivePixel(0, 0, 0);
    drivePixel(300, 300, 0);
    drivePixel(304, 300, 0);
    drivePixel(304, 300, 1);
    drivePixel(302, 301, 0);

    // Edge ball, out-of-range index on the 3-ball instance, disabled balls
    writeBall(0, 0, 0, 'hABC, 1);
    writeBall(1, 204, 200, 'h0F0, 0);
    writeBall(2, 400, 400, 'h00F, 0);
    writeBall(3, 0, 0, 'hFFF, 1);
    drivePixel(0, 0, 0);
    drivePixel(0, 0, 0);
    drivePixel(4, 0, 0);
    drivePixel(1023, 0, 0);
    drivePixel(2047, 0, 0);
    drivePixel(0, 8, 0);
    drivePixel(204, 200, 0);

    // Reset while a hit is in flight, then empty balls after the next commit
    writeBall(0, 500, 500, 'hF0F, 1);
    drivePixel(0, 0, 0);
    drivePixel(500, 504, 0);
    drivePixel(500, 505, 0);
    applyStimulus(1, 500, 505, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 500, 505, 0, 0, 0, 0, 0, 0, 0);
    drivePixel(0, 0, 0);
    drivePixel(500, 505, 0);
    repeat (4) drivePixel(900, 700, 0);

    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (sb_q.size() > 0) checkOutput("drain", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
